// File: rtl/motor_cmd_sequencer.sv
// Command front-end for the steering/drive motor controller: queues commands,
// paces steer pulse windows, slew-limits drive duty and trips a watchdog stop.
//
// state | meaning
// IDLE  | no steer window active; pops the queue head
// ISSUE | one-cycle steer trigger
// WAIT  | steer pulse window running (cmd_time*128 cycles)
// GAP   | dead time before the next pop
module motor_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int RAMP_DIV    = 1000,
    parameter int GAP_CYCLES  = 16,
    parameter int WDOG_CYCLES = 50000000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [1:0]                          cmd_type,
    input  logic [1:0]                          cmd_dir,
    input  logic [7:0]                          cmd_duty,
    input  logic [20:0]                         cmd_time,
    output logic                                steer_stby,
    output logic [1:0]                          steer_dir,
    output logic [7:0]                          steer_duty,
    output logic [20:0]                         steer_time,
    output logic                                steer_trigger,
    output logic                                drive_stby,
    output logic [1:0]                          drive_dir_a,
    output logic [1:0]                          drive_dir_b,
    output logic [7:0]                          drive_duty_a,
    output logic [7:0]                          drive_duty_b,
    output logic                                busy,
    output logic                                wdog_trip,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] RAMP_LAST = 32'(RAMP_DIV - 1);
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    localparam logic [27:0] GAP_LAST  = 28'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    typedef struct packed {
        logic        is_drive;
        logic [1:0]  dir;
        logic [7:0]  duty;
        logic [20:0] tm;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head, push_entry;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [27:0]   timer_q, timer_d;
    logic [1:0]    steer_dir_q, steer_dir_d;
    logic [7:0]    steer_duty_q, steer_duty_d;
    logic [20:0]   steer_time_q, steer_time_d;
    logic [1:0]    tgt_dir_q, tgt_dir_d, cur_dir_q, cur_dir_d;
    logic [7:0]    tgt_duty_q, tgt_duty_d, cur_duty_q, cur_duty_d;
    logic [31:0]   ramp_q, ramp_d, wdog_q, wdog_d;
    logic          trip_q, trip_d;
    logic          fifo_full, accept, is_stop, wdog_fire, stop_all;
    logic          do_push, do_pop, ramp_tick;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign cmd_ready  = !fifo_full || (cmd_type == 2'b10);
    assign accept     = cmd_valid && cmd_ready;
    assign is_stop    = accept && (cmd_type == 2'b10);
    // An accepted command in the expiry cycle keeps the watchdog quiet.
    assign wdog_fire  = !accept && !trip_q && (wdog_q == WDOG_LAST);
    assign stop_all   = is_stop || wdog_fire;
    assign do_push    = accept && !cmd_type[1];
    assign do_pop     = (state_q == S_IDLE) && (count_q != '0) && !stop_all;
    assign head       = mem_q[rd_ptr_q];
    assign push_entry = {cmd_type[0], cmd_dir, cmd_duty, cmd_time};
    assign ramp_tick  = (ramp_q == RAMP_LAST);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (stop_all) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_comb begin
        wdog_d = wdog_q;
        trip_d = trip_q;
        if (accept) begin
            wdog_d = '0;
            trip_d = 1'b0;
        end else if (wdog_q != WDOG_LAST) begin
            wdog_d = wdog_q + 32'd1;
        end else if (wdog_fire) begin
            trip_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        steer_dir_d  = steer_dir_q;
        steer_duty_d = steer_duty_q;
        steer_time_d = steer_time_q;
        tgt_dir_d    = tgt_dir_q;
        tgt_duty_d   = tgt_duty_q;
        cur_dir_d    = cur_dir_q;
        cur_duty_d   = cur_duty_q;
        ramp_d       = ramp_tick ? '0 : ramp_q + 32'd1;

        unique case (state_q)
            S_IDLE: begin
                if (do_pop && head.is_drive) begin
                    tgt_dir_d  = head.dir;
                    tgt_duty_d = head.duty;
                end else if (do_pop) begin
                    steer_dir_d  = head.dir;
                    steer_duty_d = head.duty;
                    steer_time_d = head.tm;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Window length minus one so WAIT lasts exactly cmd_time*128 cycles.
                if (steer_time_q == '0) begin
                    state_d = S_GAP;
                    timer_d = GAP_LAST;
                end else begin
                    state_d = S_WAIT;
                    timer_d = {steer_time_q, 7'd0} - 28'd1;
                end
            end
            S_WAIT: begin
                if (timer_q == '0) begin
                    state_d = S_GAP;
                    timer_d = GAP_LAST;
                end else begin
                    timer_d = timer_q - 28'd1;
                end
            end
            S_GAP: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - 28'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Reversal only happens once the motor has slewed down to zero duty.
        if (ramp_tick) begin
            if (tgt_dir_q != cur_dir_q) begin
                if (cur_duty_q != '0) cur_duty_d = cur_duty_q - 8'd1;
                else                  cur_dir_d  = tgt_dir_q;
            end else if (cur_duty_q < tgt_duty_q) begin
                cur_duty_d = cur_duty_q + 8'd1;
            end else if (cur_duty_q > tgt_duty_q) begin
                cur_duty_d = cur_duty_q - 8'd1;
            end
        end

        if (stop_all) begin
            state_d      = S_IDLE;
            timer_d      = '0;
            steer_dir_d  = '0;
            steer_duty_d = '0;
            tgt_dir_d    = '0;
            tgt_duty_d   = '0;
            cur_dir_d    = '0;
            cur_duty_d   = '0;
            ramp_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            timer_q      <= '0;
            steer_dir_q  <= '0;
            steer_duty_q <= '0;
            steer_time_q <= '0;
            tgt_dir_q    <= '0;
            tgt_duty_q   <= '0;
            cur_dir_q    <= '0;
            cur_duty_q   <= '0;
            ramp_q       <= '0;
            wdog_q       <= '0;
            trip_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            steer_dir_q  <= steer_dir_d;
            steer_duty_q <= steer_duty_d;
            steer_time_q <= steer_time_d;
            tgt_dir_q    <= tgt_dir_d;
            tgt_duty_q   <= tgt_duty_d;
            cur_dir_q    <= cur_dir_d;
            cur_duty_q   <= cur_duty_d;
            ramp_q       <= ramp_d;
            wdog_q       <= wdog_d;
            trip_q       <= trip_d;
        end
    end

    assign steer_stby    = (state_q != S_IDLE);
    assign steer_trigger = (state_q == S_ISSUE);
    assign steer_dir     = steer_dir_q;
    assign steer_duty    = steer_duty_q;
    assign steer_time    = steer_time_q;
    assign drive_stby    = (cur_duty_q != '0) || (tgt_duty_q != '0);
    assign drive_dir_a   = cur_dir_q;
    assign drive_dir_b   = cur_dir_q;
    assign drive_duty_a  = cur_duty_q;
    assign drive_duty_b  = cur_duty_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);
    assign wdog_trip     = trip_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboarded bench for motor_cmd_sequencer: steer triggers are checked by a
// monitor against queued expectations; drive, stop, watchdog and reset checks are directed.
module tb_motor_cmd_sequencer;

    localparam int FD = 4;
    localparam int RD = 4;
    localparam int GC = 2;
    localparam int WD = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_type, cmd_dir;
    logic [7:0]  cmd_duty;
    logic [20:0] cmd_time;
    logic        steer_stby, steer_trigger, drive_stby, busy, wdog_trip;
    logic [1:0]  steer_dir, drive_dir_a, drive_dir_b;
    logic [7:0]  steer_duty, drive_duty_a, drive_duty_b;
    logic [20:0] steer_time;
    logic [2:0]  fifo_count;

    motor_cmd_sequencer #(
        .FIFO_DEPTH(FD), .RAMP_DIV(RD), .GAP_CYCLES(GC), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .cmd_time(cmd_time),
        .steer_stby(steer_stby), .steer_dir(steer_dir), .steer_duty(steer_duty),
        .steer_time(steer_time), .steer_trigger(steer_trigger),
        .drive_stby(drive_stby), .drive_dir_a(drive_dir_a), .drive_dir_b(drive_dir_b),
        .drive_duty_a(drive_duty_a), .drive_duty_b(drive_duty_b),
        .busy(busy), .wdog_trip(wdog_trip), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  dir;
        logic [7:0]  duty;
        logic [20:0] tm;
        int          at;
    } trig_t;

    trig_t exp_q[$];
    trig_t mon_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Trigger monitor: every pulse must match the oldest expected steer window.
    always @(negedge clk) begin
        if (rst_n && steer_trigger) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_trigger: got a trigger at cycle %0d expected none", cyc);
            end else begin
                mon_t = exp_q.pop_front();
                check("trig_cycle", cyc, mon_t.at);
                check("trig_dir", steer_dir, mon_t.dir);
                check("trig_duty", steer_duty, mon_t.duty);
                check("trig_time", steer_time, mon_t.tm);
                check("trig_stby", steer_stby, 1);
            end
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [1:0] t, input logic [1:0] d, input logic [7:0] du,
                        input logic [20:0] tm, output int acc);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_dir   = d;
        cmd_duty  = du;
        cmd_time  = tm;
        #1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) check("send_ready_timeout", cmd_ready, 1);
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish by cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    int a1, a2, s, a, r, tmp, flip_cyc;
    int t1, t2;
    logic [1:0] prev_dir;
    logic [7:0] prev_duty;

    initial begin
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_dir   = 2'b00;
        cmd_duty  = 8'd0;
        cmd_time  = 21'd0;
        repeat (3) @(negedge clk);
        check("rst_stby", steer_stby, 0);
        check("rst_trigger", steer_trigger, 0);
        check("rst_drive_duty", drive_duty_a, 0);
        check("rst_busy", busy, 0);
        check("rst_wdog", wdog_trip, 0);
        check("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back steer windows.
        send(2'b00, 2'b10, 8'd128, 21'd3, a1);
        t1 = a1 + 1;
        exp_q.push_back('{dir: 2'b10, duty: 8'd128, tm: 21'd3, at: t1});
        send(2'b00, 2'b01, 8'd64, 21'd1, a2);
        t2 = t1 + 388;
        exp_q.push_back('{dir: 2'b01, duty: 8'd64, tm: 21'd1, at: t2});
        wait_until(t1 + 200);
        check("wait_stby", steer_stby, 1);
        check("wait_busy", busy, 1);
        check("wait_time", steer_time, 3);
        wait_until(t1 + 386);
        check("gap_stby", steer_stby, 1);
        wait_until(t1 + 387);
        check("idle_stby", steer_stby, 0);
        check("idle_busy_queued", busy, 1);
        check("idle_count", fifo_count, 1);
        wait_until(t2 + 131);
        check("done_busy", busy, 0);
        check("done_stby", steer_stby, 0);
        check("hold_dir", steer_dir, 2'b01);
        check("hold_duty", steer_duty, 64);

        // Drive ramp and reversal, phase aligned by a stop.
        send(2'b10, 2'b00, 8'd0, 21'd0, s);
        send(2'b01, 2'b10, 8'd10, 21'd0, tmp);
        wait_until(s + 4);
        check("fwd_dir", drive_dir_a, 2'b10);
        check("fwd_duty0", drive_duty_a, 0);
        wait_until(s + 43);
        check("fwd_duty9", drive_duty_a, 9);
        wait_until(s + 44);
        check("fwd_duty10", drive_duty_a, 10);
        check("fwd_duty_b", drive_duty_b, 10);
        check("fwd_stby", drive_stby, 1);
        wait_until(s + 60);
        check("fwd_sat", drive_duty_a, 10);
        send(2'b01, 2'b01, 8'd5, 21'd0, tmp);
        check("rev_accept_cycle", tmp, s + 61);
        prev_dir = drive_dir_a;
        prev_duty = drive_duty_a;
        flip_cyc = -1;
        while (cyc < s + 124) begin
            @(negedge clk);
            if (drive_dir_a != prev_dir) begin
                check("flip_at_zero", {prev_duty, drive_duty_a}, 0);
                flip_cyc = cyc;
            end
            prev_dir = drive_dir_a;
            prev_duty = drive_duty_a;
        end
        check("flip_cycle", flip_cyc, s + 104);
        check("rev_dir", drive_dir_a, 2'b01);
        check("rev_dir_b", drive_dir_b, 2'b01);
        check("rev_duty", drive_duty_a, 5);

        // Fill the queue behind an active window, then stop.
        send(2'b00, 2'b10, 8'd200, 21'd2, a);
        exp_q.push_back('{dir: 2'b10, duty: 8'd200, tm: 21'd2, at: a + 1});
        for (int i = 0; i < 4; i++) send(2'b00, 2'b01, 8'd33, 21'd2, tmp);
        #1;
        check("full_count", fifo_count, 4);
        check("full_ready", cmd_ready, 0);
        cmd_type = 2'b10;
        #1;
        check("full_stop_ready", cmd_ready, 1);
        @(negedge clk);
        send(2'b10, 2'b00, 8'd0, 21'd0, s);
        check("stop_count", fifo_count, 0);
        check("stop_steer_duty", steer_duty, 0);
        check("stop_steer_dir", steer_dir, 0);
        check("stop_drive_duty", drive_duty_a, 0);
        check("stop_stby", steer_stby, 0);
        check("stop_busy", busy, 0);
        cmd_type = 2'b00;
        #1;
        check("stop_ready", cmd_ready, 1);
        wait_until(s + 400);

        // Watchdog.
        send(2'b01, 2'b10, 8'd20, 21'd0, a);
        wait_until(a + 999);
        check("wd_pre_trip", wdog_trip, 0);
        check("wd_pre_duty", drive_duty_a, 20);
        wait_until(a + 1000);
        check("wd_trip", wdog_trip, 1);
        check("wd_duty", drive_duty_a, 0);
        check("wd_dir", drive_dir_a, 0);
        check("wd_stby", drive_stby, 0);
        wait_until(a + 1500);
        check("wd_sticky", wdog_trip, 1);
        send(2'b01, 2'b00, 8'd0, 21'd0, tmp);
        check("wd_clear", wdog_trip, 0);

        // Reset during a steer window.
        send(2'b00, 2'b10, 8'd50, 21'd3, r);
        exp_q.push_back('{dir: 2'b10, duty: 8'd50, tm: 21'd3, at: r + 1});
        wait_until(r + 100);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stby", steer_stby, 0);
        check("arst_trigger", steer_trigger, 0);
        check("arst_steer", {steer_dir, steer_duty, steer_time}, 0);
        check("arst_drive", {drive_stby, drive_dir_a, drive_dir_b, drive_duty_a, drive_duty_b}, 0);
        check("arst_busy", busy, 0);
        check("arst_wdog", wdog_trip, 0);
        check("arst_count", fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_count", fifo_count, 0);
        wait_until(cyc + 500);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Command front-end that sequences the steering/drive motor controller.
- Accepts steer/drive/stop commands over a valid/ready interface and queues them in order.
- Issues one steer trigger at a time, waiting for each pulse window to finish, and slew-limits drive duty with safe direction reversal.
- A watchdog forces a stop when commands cease. Outputs connect 1:1 to the motor controller's control inputs.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of 2, >=2).
- RAMP_DIV, 1000, clk cycles per ±1 drive duty step (>=1).
- GAP_CYCLES, 16, dead cycles after each steer window before the next pop (>=1).
- WDOG_CYCLES, 50000000, idle cycles before watchdog stop (<2^32).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: command accepted when valid&ready.
- cmd_type, in, 2: 00 steer, 01 drive, 10 stop, 11 reserved.
- cmd_dir, in, 2: 10 = left/forward, 01 = right/backward, else none/coast.
- cmd_duty, in, 8: duty 0..255.
- cmd_time, in, 21: steer window units (×128 clk).
- steer_stby, out, 1: steer driver enable.
- steer_dir, out, 2.
- steer_duty, out, 8.
- steer_time, out, 21.
- steer_trigger, out, 1: one-cycle pulse.
- drive_stby, out, 1.
- drive_dir_a, out, 2.
- drive_dir_b, out, 2.
- drive_duty_a, out, 8.
- drive_duty_b, out, 8.
- busy, out, 1: FSM not IDLE or FIFO non-empty.
- wdog_trip, out, 1: sticky watchdog flag.
- fifo_count, out, $clog2(FIFO_DEPTH+1): queued entries.

Behaviour:
- Reset: all outputs 0. FSM is IDLE, FIFO is empty, ramp/watchdog counters are 0, drive target and current direction are 00.
- cmd_ready = !fifo_full || (cmd_type==10). This is combinational on cmd_type; stop is always accepted.
- Accepted steer/drive commands push {type,dir,duty,time}. Reserved commands are accepted and dropped. Every accepted command clears the watchdog counter and clears wdog_trip.
- FSM IDLE, head = drive: pop. The next edge sets drive target = {dir,duty}. Stay in IDLE (one pop per cycle max).
- FSM IDLE, head = steer: pop. The next edge loads steer_dir/duty/time and enters ISSUE.
- FSM ISSUE: steer_trigger=1 for exactly this cycle. Go to WAIT with a 28-bit counter = cmd_time<<7.
- FSM WAIT: decrement each cycle. Leave for GAP when the counter is 0. steer_time=0 therefore spends 0 cycles in WAIT.
- FSM GAP: GAP_CYCLES cycles, then IDLE.
- Steer outputs hold their values after the window until the next steer or stop.
- steer_stby = 1 whenever state != IDLE.
- Drive ramp: free-running tick counter 0..RAMP_DIV-1; the step occurs on the count==RAMP_DIV-1 cycle.
  - If target dir != current dir and current duty > 0: duty -1 per tick.
  - If duty == 0 and dir differs: current dir <= target dir on that tick.
  - Otherwise duty moves ±1 toward target duty per tick. No overshoot; saturates at target.
- drive_duty_a = drive_duty_b = current duty. drive_dir_a = drive_dir_b = current dir; the controller handles B-side pin inversion.
- drive_stby = (current duty != 0) || (target duty != 0).
- Stop (accepted, or watchdog expiry), applied at the next edge:
  - FIFO flushed.
  - FSM to IDLE.
  - steer_dir=00, steer_duty=0, steer_trigger=0.
  - Drive target and current duty = 0 and dir = 00 immediately (no ramp).
  - Ramp counter cleared.
- Watchdog: increments each cycle with no accepted command. At count == WDOG_CYCLES-1 it performs a stop, sets wdog_trip, and holds the counter there (one stop per trip).
- Simultaneous events:
  - Stop accept and FSM pop in the same cycle: stop wins, popped entry discarded.
  - Push and pop in the same cycle: both occur, count unchanged.
  - Push while full is impossible (ready low) except stop, which flushes.
  - Command accept and watchdog expiry in the same cycle: accept wins, no trip.
- Reset mid-window: all state cleared; the steer pulse is not re-issued.

Test Plan:
(Parameters for all scenarios: RAMP_DIV=4, GAP_CYCLES=2, WDOG_CYCLES=1000, FIFO_DEPTH=4.)
- Steer dir=10 duty=128 time=3: trigger pulses 1 cycle after pop with steer_time=3. WAIT lasts 384 cycles, GAP 2, then IDLE; steer_stby high throughout.
- Two steer cmds back-to-back: second trigger occurs exactly 1+384+2+1 cycles after the first. Never two triggers overlap.
- Drive fwd duty=10: duty rises 1 per 4 cycles, reaching 10 after 40 cycles. Then backward duty=5: ramps to 0, dir flips to 01, then ramps to 5; dir never changes while duty>0.
- Fill FIFO with 4 steer cmds (cmd_ready low), then stop: ready high, FIFO empty next cycle, steer_duty=0, drive duty=0, no further triggers.
- No commands for 1000 cycles with drive duty=20: drive duty goes to 0 and wdog_trip=1. The next accepted command clears wdog_trip.
- Assert rst_n low during WAIT: all outputs 0 asynchronously, fifo_count=0, busy=0 after release.
